dmem_responder: RTL and testbench

//  Memory-side responder for the core's data/instruction memory port. Services the
//  mem_read / mem_write / mem_wrbits requests issued by the controller.

---
 rtl/dmem_responder_pkg.sv | 38 +++
 rtl/dmem_responder_ram.sv | 34 +++
 rtl/dmem_responder.sv | 150 +++++++++++++++
 tb/tb_dmem_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: FSM states, op kinds,
// the latched request record and the legal byte-lane write patterns.
package dmem_responder_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    // Byte, aligned-half and full-word lane patterns, plus the all-zero no-op.
    localparam logic [7:0][3:0] LEGAL_WRBITS = {
        4'b0001, 4'b0010, 4'b0100, 4'b1000,
        4'b0011, 4'b1100, 4'b1111, 4'b0000
    };

    typedef struct packed {
        op_e        op;
        logic       err;
        logic [3:0] wrbits;
        logic [31:0] wdata;
    } req_t;

    function automatic logic wrbits_legal(input logic [3:0] bits);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (bits == LEGAL_WRBITS[k]) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_responder_ram.sv
// Single-port word RAM with per-byte write enables and one registered read port.
// Contents are deliberately not reset.
import dmem_responder_pkg::*;

module dmem_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              rd_en,
    input  logic [3:0]        wr_be,
    input  logic [ADDR_W-3:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (rd_en) begin
            rdata_q <= mem[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency memory responder: accepts one read/write in IDLE, counts WAIT
// cycles, then pulses ready for one cycle with the result or an error.
import dmem_responder_pkg::*;

module dmem_responder #(
    parameter int ADDR_W = 12,
    parameter int WAIT   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_wrbits,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    req_t              req_q, req_d;
    logic [ADDR_W-3:0] idx_q, idx_d;

    req_t              new_req;
    logic              accept;
    logic              ram_rd_en;
    logic [3:0]        ram_be;
    logic [ADDR_W-3:0] ram_idx;
    logic [31:0]       ram_rdata;
    logic              resp_is_read;

    // Byte offset within the word plays no part in a full-word access.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    assign accept = (state_q == S_IDLE) && (mem_read || mem_write);

    always_comb begin
        new_req.op     = mem_write ? OP_WR : OP_RD;
        new_req.wrbits = mem_wrbits;
        new_req.wdata  = wdata;
        new_req.err    = (mem_read && mem_write)
                       || ((addr >> ADDR_W) != 32'd0)
                       || (mem_write && !wrbits_legal(mem_wrbits));
    end

    assign resp_is_read = (req_q.op == OP_RD) && !req_q.err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        req_d   = req_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    req_d   = new_req;
                    idx_d   = addr[ADDR_W-1:2];
                    cnt_d   = WAIT_CNT;
                    state_d = (WAIT == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (req_q.err) begin
                    rdata_d = 32'd0;
                end else if (req_q.op == OP_RD) begin
                    rdata_d = ram_rdata;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reads are launched on the edge entering RESP so the word is on the port
    // during the ready cycle; writes commit on the edge leaving RESP, so a
    // reset anywhere before that edge drops the write.
    always_comb begin
        ram_rd_en = 1'b0;
        if ((state_q == S_IDLE) && accept && (WAIT == 0)) begin
            ram_rd_en = (new_req.op == OP_RD) && !new_req.err;
        end else if ((state_q == S_WAIT) && (cnt_q <= 4'd1)) begin
            ram_rd_en = resp_is_read;
        end
    end

    assign ram_idx = (state_q == S_IDLE) ? addr[ADDR_W-1:2] : idx_q;
    assign ram_be  = ((state_q == S_RESP) && (req_q.op == OP_WR) && !req_q.err)
                   ? req_q.wrbits : 4'b0000;

    dmem_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clock (clock),
        .rd_en (ram_rd_en),
        .wr_be (ram_be),
        .idx   (ram_idx),
        .wdata (req_q.wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Request payload is only consulted outside IDLE, so it needs no reset.
    always_ff @(posedge clock) begin
        req_q <= req_d;
        idx_q <= idx_d;
    end

    assign busy  = (state_q != S_IDLE);
    assign ready = (state_q == S_RESP);
    assign err   = ready && req_q.err;

    always_comb begin
        rdata = rdata_q;
        if (state_q == S_RESP) begin
            if (req_q.err) begin
                rdata = 32'd0;
            end else if (req_q.op == OP_RD) begin
                rdata = ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (WAIT=1, 0, 3) share
// clock and reset; expected responses are queued per instance at issue time.
module tb_dmem_responder;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic        rd_i    [3];
    logic        wr_i    [3];
    logic [3:0]  bits_i  [3];
    logic [31:0] addr_i  [3];
    logic [31:0] wdata_i [3];
    logic [31:0] rdata_o [3];
    logic        ready_o [3];
    logic        busy_o  [3];
    logic        err_o   [3];

    dmem_responder #(.ADDR_W(12), .WAIT(1)) u_w1 (
        .clock(clock), .reset(reset), .mem_read(rd_i[0]), .mem_write(wr_i[0]),
        .mem_wrbits(bits_i[0]), .addr(addr_i[0]), .wdata(wdata_i[0]),
        .rdata(rdata_o[0]), .ready(ready_o[0]), .busy(busy_o[0]), .err(err_o[0]));

    dmem_responder #(.ADDR_W(12), .WAIT(0)) u_w0 (
        .clock(clock), .reset(reset), .mem_read(rd_i[1]), .mem_write(wr_i[1]),
        .mem_wrbits(bits_i[1]), .addr(addr_i[1]), .wdata(wdata_i[1]),
        .rdata(rdata_o[1]), .ready(ready_o[1]), .busy(busy_o[1]), .err(err_o[1]));

    dmem_responder #(.ADDR_W(12), .WAIT(3)) u_w3 (
        .clock(clock), .reset(reset), .mem_read(rd_i[2]), .mem_write(wr_i[2]),
        .mem_wrbits(bits_i[2]), .addr(addr_i[2]), .wdata(wdata_i[2]),
        .rdata(rdata_o[2]), .ready(ready_o[2]), .busy(busy_o[2]), .err(err_o[2]));

    int n_checks = 0;
    int n_errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   rdy_cyc  [3] = '{0, 0, 0};
    int   prev_rdy [3] = '{0, 0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int wait_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic int q_size(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push_exp(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int i, output exp_t e);
        case (i)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (ready_o[i]) begin
                prev_rdy[i] = rdy_cyc[i];
                rdy_cyc[i]  = cyc;
                if (q_size(i) == 0) begin
                    check($sformatf("u%0d_unexpected_ready", i), 32'(ready_o[i]), 32'd0);
                end else begin
                    exp_t e;
                    pop_exp(i, e);
                    check($sformatf("u%0d_err", i), 32'(err_o[i]), 32'(e.err));
                    check($sformatf("u%0d_rdata", i), rdata_o[i], e.rdata);
                    check($sformatf("u%0d_ready_cycle", i), 32'(cyc), 32'(e.cyc));
                end
            end else if (err_o[i]) begin
                check($sformatf("u%0d_err_without_ready", i), 32'(err_o[i]), 32'd0);
            end
        end
    end

    // Present a request for one sampling edge; optionally queue its expected response.
    task automatic issue(input int i, input logic rd, input logic wr, input logic [3:0] bits,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic xerr, input logic [31:0] xrd, input bit push);
        exp_t e;
        rd_i[i]    = rd;
        wr_i[i]    = wr;
        bits_i[i]  = bits;
        addr_i[i]  = a;
        wdata_i[i] = d;
        if (push) begin
            e.err   = xerr;
            e.rdata = xrd;
            e.cyc   = cyc + 1 + wait_of(i);
            push_exp(i, e);
        end
        @(posedge clock);
        #1;
        rd_i[i] = 1'b0;
        wr_i[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        int n = 0;
        while ((busy_o[i] || q_size(i) != 0) && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 40) begin
            check($sformatf("u%0d_response_timeout", i),
                  32'(q_size(i)) + 32'(busy_o[i]), 32'd0);
        end
    endtask

    task automatic wr(input int i, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] bits, input logic xerr, input logic [31:0] xrd);
        issue(i, 1'b0, 1'b1, bits, a, d, xerr, xrd, 1'b1);
        wait_done(i);
    endtask

    task automatic rdt(input int i, input logic [31:0] a, input logic xerr, input logic [31:0] xrd);
        issue(i, 1'b1, 1'b0, 4'b0000, a, 32'd0, xerr, xrd, 1'b1);
        wait_done(i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rd_i[i] = 1'b0; wr_i[i] = 1'b0; bits_i[i] = 4'b0000;
            addr_i[i] = 32'd0; wdata_i[i] = 32'd0;
        end
        reset = 1'b1;
        #2;
        check("reset_ready", 32'(ready_o[0]), 32'd0);
        check("reset_busy", 32'(busy_o[0]), 32'd0);
        check("reset_err", 32'(err_o[0]), 32'd0);
        check("reset_rdata", rdata_o[0], 32'd0);
        check("reset_busy_w3", 32'(busy_o[2]), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Full-word write with busy/ready timing around the accept edge.
        issue(0, 1'b0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
        check("t1_busy_c1", 32'(busy_o[0]), 32'd1);
        check("t1_ready_c1", 32'(ready_o[0]), 32'd0);
        @(posedge clock);
        #1;
        check("t1_busy_c2", 32'(busy_o[0]), 32'd1);
        check("t1_ready_c2", 32'(ready_o[0]), 32'd1);
        @(posedge clock);
        #1;
        check("t1_busy_c3", 32'(busy_o[0]), 32'd0);
        wait_done(0);
        rdt(0, 32'h10, 1'b0, 32'hDEADBEEF);

        // Byte and half-word lane writes.
        wr(0, 32'h10, 32'h11223344, 4'b1111, 1'b0, 32'hDEADBEEF);
        wr(0, 32'h11, 32'h0000AA00, 4'b0010, 1'b0, 32'hDEADBEEF);
        rdt(0, 32'h11, 1'b0, 32'h1122AA44);
        wr(0, 32'h12, 32'h55660000, 4'b1100, 1'b0, 32'h1122AA44);
        rdt(0, 32'h13, 1'b0, 32'h5566AA44);
        wr(0, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'h5566AA44);
        rdt(0, 32'h10, 1'b0, 32'h5566AA44);

        // Rejected requests leave RAM untouched and zero rdata.
        issue(0, 1'b1, 1'b1, 4'b1111, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1);
        wait_done(0);
        rdt(0, 32'h10, 1'b0, 32'h5566AA44);
        rdt(0, 32'h1000, 1'b1, 32'h0);
        wr(0, 32'h10, 32'h0, 4'b0101, 1'b1, 32'h0);
        rdt(0, 32'h10, 1'b0, 32'h5566AA44);

        // A pulse during WAIT is dropped; a re-assert in IDLE is served.
        issue(0, 1'b1, 1'b0, 4'b0000, 32'h10, 32'h0, 1'b0, 32'h5566AA44, 1'b1);
        issue(0, 1'b1, 1'b0, 4'b0000, 32'h1000, 32'h0, 1'b0, 32'h0, 1'b0);
        wait_done(0);
        repeat (4) @(posedge clock);
        #1;
        rdt(0, 32'h13, 1'b0, 32'h5566AA44);

        // Reset in WAIT of a write: outputs clear at once, write never lands.
        wr(0, 32'h20, 32'h01020304, 4'b1111, 1'b0, 32'h5566AA44);
        rdt(0, 32'h20, 1'b0, 32'h01020304);
        issue(0, 1'b0, 1'b1, 4'b1111, 32'h20, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0);
        check("t5_busy_before_reset", 32'(busy_o[0]), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_busy_in_reset", 32'(busy_o[0]), 32'd0);
        check("t5_ready_in_reset", 32'(ready_o[0]), 32'd0);
        check("t5_err_in_reset", 32'(err_o[0]), 32'd0);
        check("t5_rdata_in_reset", rdata_o[0], 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        rdt(0, 32'h20, 1'b0, 32'h01020304);

        // Back-to-back reads at WAIT=0 and WAIT=3.
        wr(1, 32'h40, 32'hCAFEF00D, 4'b1111, 1'b0, 32'h0);
        rdt(1, 32'h40, 1'b0, 32'hCAFEF00D);
        rdt(1, 32'h40, 1'b0, 32'hCAFEF00D);
        check("t6_spacing_wait0", 32'(rdy_cyc[1] - prev_rdy[1]), 32'd2);
        rdt(1, 32'h1004, 1'b1, 32'h0);

        wr(2, 32'h44, 32'h0BADC0DE, 4'b1111, 1'b0, 32'h0);
        rdt(2, 32'h44, 1'b0, 32'h0BADC0DE);
        rdt(2, 32'h44, 1'b0, 32'h0BADC0DE);
        check("t6_spacing_wait3", 32'(rdy_cyc[2] - prev_rdy[2]), 32'd5);
        wr(2, 32'h46, 32'h00770000, 4'b0100, 1'b0, 32'h0BADC0DE);
        rdt(2, 32'h44, 1'b0, 32'h0B77C0DE);

        repeat (5) @(posedge clock);
        #1;
        check("scoreboard_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
